// File: rtl/press_event_gen_pkg.sv
// Shared types and width helpers for the press event generator.
package press_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } press_state_e;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 16;
    localparam int unsigned DEF_LONG_CYCLES   = 1000;
    localparam int unsigned DEF_STABLE_W      = cnt_w(DEF_STABLE_CYCLES);
    localparam int unsigned DEF_HOLD_W        = cnt_w(DEF_LONG_CYCLES);

endpackage

// File: rtl/press_event_gen_sync_debounce.sv
// Synchronizer plus stability filter for a raw asynchronous input.
module sync_debounce
    import press_event_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = cnt_w(STABLE_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_in};
        synced  = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        level_d = level_q;
        // Any sample matching the current level restarts the count.
        if (synced != level_q) begin
            if (cnt_q == CW'(STABLE_CYCLES)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = level_d & ~level_q;
    assign o_fall  = ~level_d & level_q;

endmodule

// File: rtl/press_event_gen.sv
// Turns a debounced button into one-cycle count-enable / clear strobes.
module press_event_gen
    import press_event_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_en,
    output logic o_clear
);

    localparam int unsigned HW = cnt_w(LONG_CYCLES);

    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("LONG_CYCLES must be >= 2");
    end

    logic         rise, fall;
    press_state_e state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic         en_q, en_d;
    logic         clear_q, clear_d;

    sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_deb (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_in   (i_in),
        .o_level(o_level),
        .o_rise (rise),
        .o_fall (fall)
    );

    // rise/fall announce the level change landing on this edge,
    // so strobes line up with the registered o_level edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        en_d    = 1'b0;
        clear_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    hold_d  = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (hold_q != HW'(LONG_CYCLES)) begin
                    hold_d = hold_q + HW'(1);
                end
                if (hold_q == HW'(LONG_CYCLES - 1)) begin
                    en_d    = 1'b1;
                    clear_d = 1'b1;
                    state_d = fall ? ST_IDLE : ST_HELD;
                end else if (fall) begin
                    en_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            en_q    <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            clear_q <= clear_d;
        end
    end

    assign o_en    = en_q;
    assign o_clear = clear_q;

endmodule

// File: tb/tb_press_event_gen.sv
// Directed bench for press_event_gen (SYNC=2, STABLE=4, LONG=20).
module tb_press_event_gen;

    logic i_clk;
    logic i_rst_n;
    logic i_in;
    logic o_level;
    logic o_en;
    logic o_clear;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int rise_cyc  = -1;
    int fall_cyc  = -1;
    int en_cyc    = -1;
    int rise_cnt  = 0;
    int en_cnt    = 0;
    int clear_cnt = 0;
    int orphan    = 0;
    logic lvl_p   = 1'b0;

    press_event_gen #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (20)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_in   (i_in),
        .o_level(o_level),
        .o_en   (o_en),
        .o_clear(o_clear)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // Event log sampled 1 time unit after each edge.
    always @(posedge i_clk) begin
        #1;
        if (o_level && !lvl_p) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        if (!o_level && lvl_p) fall_cyc = cyc;
        if (o_en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (o_clear) clear_cnt++;
        if (o_clear && !o_en) orphan++;
        lvl_p = o_level;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic clr();
        rise_cyc  = -1;
        fall_cyc  = -1;
        en_cyc    = -1;
        rise_cnt  = 0;
        en_cnt    = 0;
        clear_cnt = 0;
    endtask

    task automatic press(input int len, output int c0);
        i_in = 1'b1;
        c0   = cyc;
        idle(len);
        i_in = 1'b0;
    endtask

    int c, c2, r;

    initial begin
        i_in    = 1'b0;
        i_rst_n = 1'b0;
        idle(3);
        check("rst_level", int'(o_level), 0);
        check("rst_en", int'(o_en), 0);
        check("rst_clear", int'(o_clear), 0);
        i_rst_n = 1'b1;
        idle(3);

        // clean short press
        clr();
        press(10, c);
        idle(20);
        check("s_rise", rise_cyc, c + 7);
        check("s_fall", fall_cyc, c + 17);
        check("s_en_n", en_cnt, 1);
        check("s_en_at", en_cyc, c + 17);
        check("s_clr_n", clear_cnt, 0);

        // bounce: 3-cycle runs
        clr();
        repeat (7) begin
            i_in = 1'b1;
            idle(3);
            i_in = 1'b0;
            idle(3);
        end
        idle(20);
        check("b_rise_n", rise_cnt, 0);
        check("b_en_n", en_cnt, 0);
        check("b_clr_n", clear_cnt, 0);

        // long press
        clr();
        press(40, c);
        idle(20);
        check("l_rise", rise_cyc, c + 7);
        check("l_en_n", en_cnt, 1);
        check("l_clr_n", clear_cnt, 1);
        check("l_en_at", en_cyc, c + 27);
        check("l_fall", fall_cyc, c + 47);

        // 19 cycles high: short
        clr();
        press(19, c);
        idle(20);
        check("t19_en_n", en_cnt, 1);
        check("t19_clr_n", clear_cnt, 0);
        check("t19_en_at", en_cyc, c + 26);

        // 20 cycles high: fall on threshold, long wins
        clr();
        press(20, c);
        idle(20);
        check("t20_fall", fall_cyc, c + 27);
        check("t20_en_n", en_cnt, 1);
        check("t20_clr_n", clear_cnt, 1);
        check("t20_en_at", en_cyc, c + 27);

        // 21 cycles high: must start from IDLE again
        clr();
        press(21, c);
        idle(20);
        check("t21_en_n", en_cnt, 1);
        check("t21_clr_n", clear_cnt, 1);
        check("t21_en_at", en_cyc, c + 27);
        check("t21_fall", fall_cyc, c + 28);

        // reset at hold count 10
        clr();
        i_in = 1'b1;
        c = cyc;
        idle(17);
        check("r_pre_rise", rise_cyc, c + 7);
        i_rst_n = 1'b0;
        #1;
        check("r_level", int'(o_level), 0);
        check("r_en", int'(o_en), 0);
        check("r_clear", int'(o_clear), 0);
        idle(2);
        i_rst_n = 1'b1;
        r = cyc;
        clr();
        idle(10);
        check("r_rise", rise_cyc, r + 7);
        check("r_no_strobe", en_cnt, 0);
        i_in = 1'b0;
        idle(20);
        check("r_new_en_n", en_cnt, 1);
        check("r_new_clr_n", clear_cnt, 0);
        check("r_new_en_at", en_cyc, r + 17);

        // back-to-back presses
        clr();
        press(8, c);
        idle(6);
        press(8, c2);
        idle(20);
        check("bb_rise_n", rise_cnt, 2);
        check("bb_en_n", en_cnt, 2);
        check("bb_clr_n", clear_cnt, 0);
        check("bb_en_at", en_cyc, c2 + 15);
        check("bb_gap", c2 - c, 14);

        check("clr_wo_en", orphan, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
